// File: rtl/instr_fetch_unit.sv
// Fetch/IR stage of the multicycle CPU. Fetches instruction words over a req/ack handshake,
// holds them in IR for the control FSM, then advances PC sequentially or by redirect.
//
// state | meaning
// IDLE  | post-reset bubble, no request
// FETCH | mem_req held with mem_addr=pc until mem_ack
// HOLD  | IR valid for the controller, waiting for ctrl_done
// HALT  | halt opcode retired, no further fetches until reset

module instr_fetch_unit #(
    parameter int unsigned         ADDR_W   = 32,
    parameter int unsigned         DATA_W   = 32,
    parameter logic [ADDR_W-1:0]   RESET_PC = '0,
    parameter logic [5:0]          HALT_OP  = 6'h3F
) (
    input  logic              clk,
    input  logic              reset,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              ir_valid,
    output logic [DATA_W-1:0] ir,
    output logic [5:0]        opcode,
    output logic [4:0]        rs,
    output logic [4:0]        rt,
    output logic [4:0]        rd,
    output logic [15:0]       imm,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_plus4,
    input  logic              ctrl_done,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              halted,
    output logic [31:0]       retired
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2,
        HALT  = 2'd3
    } state_t;

    state_t state;
    state_t state_next;

    logic              ack_take;
    logic              retire;
    logic [ADDR_W-1:0] pc_target;

    assign ack_take = (state == FETCH) && mem_ack;
    assign retire   = (state == HOLD) && ctrl_done;

    // Redirect targets are forced word aligned by masking the two low bits.
    assign pc_plus4  = pc + ADDR_W'(4);
    assign pc_target = redirect ? (redirect_pc & ~ADDR_W'(3)) : pc_plus4;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:  state_next = FETCH;
            FETCH: if (mem_ack) state_next = HOLD;
            HOLD: begin
                if (ctrl_done) begin
                    state_next = (opcode == HALT_OP) ? HALT : FETCH;
                end
            end
            HALT:  state_next = HALT;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        mem_req  = 1'b0;
        ir_valid = 1'b0;
        halted   = 1'b0;
        case (state)
            FETCH:   mem_req  = 1'b1;
            HOLD:    ir_valid = 1'b1;
            HALT:    halted   = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc      <= RESET_PC;
            ir      <= '0;
            retired <= '0;
        end else begin
            if (ack_take) begin
                ir <= mem_rdata;
            end
            if (retire) begin
                retired <= retired + 32'd1;
                pc      <= pc_target;
            end
        end
    end

    assign mem_addr = pc;
    assign opcode   = ir[31:26];
    assign rs       = ir[25:21];
    assign rt       = ir[20:16];
    assign rd       = ir[15:11];
    assign imm      = ir[15:0];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: directed fetch/retire sequences with queued
// expected fetch addresses and IR contents, plus a second instance for PC wrap-around.

module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset = 1'b1;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        ctrl_done = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        mem_req, ir_valid, halted;
    logic [31:0] mem_addr, ir, pc, pc_plus4, retired;
    logic [5:0]  opcode;
    logic [4:0]  rs, rt, rd;
    logic [15:0] imm;

    instr_fetch_unit dut (
        .clk(clk), .reset(reset), .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .ir_valid(ir_valid), .ir(ir),
        .opcode(opcode), .rs(rs), .rt(rt), .rd(rd), .imm(imm), .pc(pc),
        .pc_plus4(pc_plus4), .ctrl_done(ctrl_done), .redirect(redirect),
        .redirect_pc(redirect_pc), .halted(halted), .retired(retired)
    );

    logic        w_reset = 1'b1;
    logic        w_mem_ack = 1'b0;
    logic        w_ctrl_done = 1'b0;
    logic        w_mem_req, w_ir_valid, w_halted;
    logic [31:0] w_mem_addr, w_ir, w_pc, w_pc_plus4, w_retired;
    logic [5:0]  w_opcode;
    logic [4:0]  w_rs, w_rt, w_rd;
    logic [15:0] w_imm;

    instr_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk(clk), .reset(w_reset), .mem_req(w_mem_req), .mem_addr(w_mem_addr),
        .mem_ack(w_mem_ack), .mem_rdata(32'h0000_0000), .ir_valid(w_ir_valid), .ir(w_ir),
        .opcode(w_opcode), .rs(w_rs), .rt(w_rt), .rd(w_rd), .imm(w_imm), .pc(w_pc),
        .pc_plus4(w_pc_plus4), .ctrl_done(w_ctrl_done), .redirect(1'b0),
        .redirect_pc(32'h0), .halted(w_halted), .retired(w_retired)
    );

    typedef struct {
        logic [31:0] ir;
        logic [31:0] pc;
        logic [5:0]  op;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [15:0] imm;
    } exp_ir_t;

    logic [31:0] exp_addr_q[$];
    exp_ir_t     exp_ir_q[$];

    int checks = 0;
    int passed = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Monitor: compares each new fetch request and each newly valid IR against the queues.
    logic prev_req = 1'b0;
    logic prev_valid = 1'b0;
    always @(negedge clk) begin
        if (mem_req && !prev_req) begin
            if (exp_addr_q.size() == 0) chk("unexpected_fetch", mem_addr, 32'hXXXX_XXXX);
            else chk("fetch_addr", mem_addr, exp_addr_q.pop_front());
        end
        if (ir_valid && !prev_valid) begin
            if (exp_ir_q.size() == 0) begin
                chk("unexpected_ir", ir, 32'hXXXX_XXXX);
            end else begin
                exp_ir_t e;
                e = exp_ir_q.pop_front();
                chk("ir", ir, e.ir);
                chk("ir_pc", pc, e.pc);
                chk("opcode", {26'd0, opcode}, {26'd0, e.op});
                chk("rs", {27'd0, rs}, {27'd0, e.rs});
                chk("rt", {27'd0, rt}, {27'd0, e.rt});
                chk("rd", {27'd0, rd}, {27'd0, e.rd});
                chk("imm", {16'd0, imm}, {16'd0, e.imm});
            end
        end
        prev_req   = mem_req;
        prev_valid = ir_valid;
    end

    task automatic wait_req(input string name);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (mem_req) break;
        end
        if (!mem_req) chk(name, {31'd0, mem_req}, 32'd1);
    endtask

    task automatic ack_after(input int wait_cyc, input logic [31:0] data);
        wait_req("timeout_req");
        repeat (wait_cyc) @(negedge clk);
        mem_ack   = 1'b1;
        mem_rdata = data;
        @(negedge clk);
        mem_ack   = 1'b0;
    endtask

    task automatic wait_valid(input string name);
        for (int i = 0; i < 50; i++) begin
            if (ir_valid) break;
            @(negedge clk);
        end
        if (!ir_valid) chk(name, {31'd0, ir_valid}, 32'd1);
    endtask

    task automatic done(input logic redir, input logic [31:0] target);
        wait_valid("timeout_valid");
        ctrl_done   = 1'b1;
        redirect    = redir;
        redirect_pc = target;
        @(negedge clk);
        ctrl_done = 1'b0;
        redirect  = 1'b0;
    endtask

    initial begin
        int req_seen;

        // 1: reset then idle
        repeat (2) @(negedge clk);
        chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("rst_pc", pc, 32'd0);
        chk("rst_ir_valid", {31'd0, ir_valid}, 32'd0);
        chk("rst_retired", retired, 32'd0);
        chk("rst_ir", ir, 32'd0);
        chk("rst_halted", {31'd0, halted}, 32'd0);
        exp_addr_q.push_back(32'h0);
        reset = 1'b0;
        @(negedge clk);
        chk("first_req_latency", {31'd0, mem_req}, 32'd1);

        // 2: sequential fetch with 3-cycle memory wait
        exp_ir_q.push_back('{32'h8C22_0004, 32'h0, 6'h23, 5'd1, 5'd2, 5'd0, 16'h0004});
        ack_after(3, 32'h8C22_0004);
        chk("valid_after_ack", {31'd0, ir_valid}, 32'd1);
        exp_addr_q.push_back(32'h4);
        done(1'b0, 32'h0);
        chk("seq_retired", retired, 32'd1);
        chk("seq_valid_drop", {31'd0, ir_valid}, 32'd0);
        chk("seq_pc", pc, 32'h4);

        // 3: redirect; stray redirect and mem_ack in HOLD are ignored
        exp_ir_q.push_back('{32'h0123_4567, 32'h4, 6'h00, 5'd9, 5'd3, 5'd8, 16'h4567});
        ack_after(0, 32'h0123_4567);
        redirect = 1'b1; redirect_pc = 32'h0000_0300; mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        redirect = 1'b0; mem_ack = 1'b0;
        @(negedge clk);
        chk("stray_redirect_pc", pc, 32'h4);
        chk("stray_ack_ir", ir, 32'h0123_4567);
        chk("hold_still_valid", {31'd0, ir_valid}, 32'd1);
        exp_addr_q.push_back(32'h100);
        done(1'b1, 32'h0000_0103);
        chk("redir_pc", pc, 32'h100);
        chk("redir_retired", retired, 32'd2);
        ctrl_done = 1'b1;
        @(negedge clk);
        ctrl_done = 1'b0;
        @(negedge clk);
        chk("done_in_fetch_retired", retired, 32'd2);
        chk("done_in_fetch_req", {31'd0, mem_req}, 32'd1);

        // 4: halt opcode together with redirect
        exp_ir_q.push_back('{32'hFC00_0000, 32'h100, 6'h3F, 5'd0, 5'd0, 5'd0, 16'h0000});
        ack_after(0, 32'hFC00_0000);
        done(1'b1, 32'h0000_0200);
        chk("halted", {31'd0, halted}, 32'd1);
        chk("halt_pc", pc, 32'h200);
        chk("halt_retired", retired, 32'd3);
        chk("halt_ir_valid", {31'd0, ir_valid}, 32'd0);
        req_seen = 0;
        for (int i = 0; i < 20; i++) begin
            ctrl_done = (i == 5);
            mem_ack   = (i == 8);
            @(negedge clk);
            if (mem_req) req_seen++;
        end
        ctrl_done = 1'b0; mem_ack = 1'b0;
        chk("halt_no_req", req_seen, 32'd0);
        chk("halt_retired_hold", retired, 32'd3);
        chk("halt_stays", {31'd0, halted}, 32'd1);

        // 5: reset mid-fetch with coincident ack
        reset = 1'b1;
        @(negedge clk);
        exp_addr_q.push_back(32'h0);
        reset = 1'b0;
        wait_req("timeout_req_r5");
        reset = 1'b1; mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        mem_ack = 1'b0;
        chk("mid_rst_ir", ir, 32'h0);
        chk("mid_rst_pc", pc, 32'h0);
        chk("mid_rst_req", {31'd0, mem_req}, 32'd0);
        chk("mid_rst_valid", {31'd0, ir_valid}, 32'd0);
        chk("mid_rst_retired", retired, 32'd0);
        chk("mid_rst_halted", {31'd0, halted}, 32'd0);
        exp_addr_q.push_back(32'h0);
        reset = 1'b0;
        exp_ir_q.push_back('{32'h2000_0010, 32'h0, 6'h08, 5'd0, 5'd0, 5'd0, 16'h0010});
        ack_after(1, 32'h2000_0010);
        @(negedge clk);

        // 6: PC wrap on the second instance
        chk("wrap_rst_pc", w_pc, 32'hFFFF_FFFC);
        chk("wrap_rst_plus4", w_pc_plus4, 32'h0);
        w_reset = 1'b0;
        for (int i = 0; i < 10 && !w_mem_req; i++) @(negedge clk);
        chk("wrap_req", {31'd0, w_mem_req}, 32'd1);
        chk("wrap_addr0", w_mem_addr, 32'hFFFF_FFFC);
        w_mem_ack = 1'b1;
        @(negedge clk);
        w_mem_ack = 1'b0;
        chk("wrap_valid", {31'd0, w_ir_valid}, 32'd1);
        chk("wrap_plus4", w_pc_plus4, 32'h0);
        w_ctrl_done = 1'b1;
        @(negedge clk);
        w_ctrl_done = 1'b0;
        chk("wrap_next_req", {31'd0, w_mem_req}, 32'd1);
        chk("wrap_next_addr", w_mem_addr, 32'h0);
        chk("wrap_retired", w_retired, 32'd1);

        repeat (2) @(negedge clk);
        chk("addr_q_empty", exp_addr_q.size(), 32'd0);
        chk("ir_q_empty", exp_ir_q.size(), 32'd0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
